// File: rtl/lo_sequencer.sv
// lo_sequencer: quarter-rate LO code generator for the IQ demodulator, with a
// programmable sample strobe, start/stop sequencing and an LO period counter.
module lo_sequencer #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       phase_init,
    input  logic             invert,
    input  logic [DIV_W-1:0] div,
    output logic [1:0]       sine_out,
    output logic [1:0]       cosine_out,
    output logic [1:0]       phase,
    output logic             sample_strobe,
    output logic             busy,
    output logic [CNT_W-1:0] lo_cycles
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;
    state_t           state, state_n;
    logic [DIV_W-1:0] div_l, div_l_n, div_cnt, div_cnt_n;
    logic             inv_l, inv_l_n;
    logic [1:0]       phase_n, phase_step, sine_n, cosine_n;
    logic [CNT_W-1:0] lo_n;
    logic             strobe_n, busy_n, tick, wrap, active;
    always_comb begin
        tick       = div_cnt == div_l;
        wrap       = inv_l ? phase == 2'd0 : phase == 2'd3;
        phase_step = inv_l ? phase - 2'd1 : phase + 2'd1;
        state_n    = state;
        div_l_n    = div_l;
        inv_l_n    = inv_l;
        div_cnt_n  = div_cnt;
        phase_n    = phase;
        lo_n       = lo_cycles;
        strobe_n   = 1'b0;
        case (state)
            IDLE: state_n = enable ? ARM : IDLE;
            ARM: begin
                state_n   = RUN;
                div_l_n   = div;
                inv_l_n   = invert;
                phase_n   = phase_init;
                div_cnt_n = '0;
                lo_n      = '0;
                strobe_n  = 1'b1;
            end
            default: begin
                // STOP drains to the end of the current period unless re-enabled
                if (state == STOP && !enable && tick) begin
                    state_n   = IDLE;
                    div_cnt_n = '0;
                end else begin
                    state_n   = enable ? RUN : STOP;
                    div_cnt_n = tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        phase_n  = phase_step;
                        strobe_n = 1'b1;
                        lo_n     = lo_cycles + CNT_W'(wrap);
                    end
                end
            end
        endcase
        busy_n   = state_n != IDLE;
        active   = state_n == RUN || state_n == STOP;
        sine_n   = !active ? 2'b00 : phase_n == 2'd1 ? 2'b01 : phase_n == 2'd3 ? 2'b11 : 2'b00;
        cosine_n = !active ? 2'b00 : phase_n == 2'd0 ? 2'b01 : phase_n == 2'd2 ? 2'b11 : 2'b00;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            div_l         <= '0;
            inv_l         <= 1'b0;
            div_cnt       <= '0;
            phase         <= 2'd0;
            lo_cycles     <= '0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
            sine_out      <= 2'b00;
            cosine_out    <= 2'b00;
        end else begin
            state         <= state_n;
            div_l         <= div_l_n;
            inv_l         <= inv_l_n;
            div_cnt       <= div_cnt_n;
            phase         <= phase_n;
            lo_cycles     <= lo_n;
            sample_strobe <= strobe_n;
            busy          <= busy_n;
            sine_out      <= sine_n;
            cosine_out    <= cosine_n;
        end
    end
endmodule

// File: tb/tb_lo_sequencer.sv
// tb_lo_sequencer: directed scenario tests for lo_sequencer.
module tb_lo_sequencer;
    logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, invert = 1'b0;
    logic [1:0] phase_init = 2'd0;
    logic [3:0] div = 4'd0;
    logic [1:0] sine_out, cosine_out, phase;
    logic       sample_strobe, busy;
    logic [7:0] lo_cycles;
    logic [7:0] obs;
    int checks = 0, errors = 0;
    // obs = {sine, cosine, phase, strobe, busy}; strobe codes per phase, hold codes are these minus 2
    localparam logic [7:0] STRB [4] = '{8'h13, 8'h47, 8'h3B, 8'hCF};

    lo_sequencer #(.DIV_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .phase_init(phase_init),
        .invert(invert), .div(div), .sine_out(sine_out), .cosine_out(cosine_out),
        .phase(phase), .sample_strobe(sample_strobe), .busy(busy), .lo_cycles(lo_cycles)
    );

    assign obs = {sine_out, cosine_out, phase, sample_strobe, busy};
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        step();
        checks++;
        if ({obs, lo_cycles} !== 16'h0) begin errors++; $display("FAIL reset_state obs=%h lo=%0d exp=00 lo=0", obs, lo_cycles); end
        reset = 1'b0;
        step();
        checks++;
        if ({obs, lo_cycles} !== 16'h0) begin errors++; $display("FAIL idle_after_reset obs=%h lo=%0d exp=00 lo=0", obs, lo_cycles); end
    endtask

    task automatic test_div0;
        logic [1:0] ph [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        enable = 1'b1; phase_init = 2'd0; invert = 1'b0; div = 4'd0;
        step();
        checks++;
        if (obs !== 8'h01) begin errors++; $display("FAIL div0_arm obs=%h exp=01", obs); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (obs !== STRB[ph[k]] || lo_cycles !== ((k == 4) ? 8'd1 : 8'd0))
                begin errors++; $display("FAIL div0_seq%0d obs=%h lo=%0d exp=%h lo=%0d", k, obs, lo_cycles, STRB[ph[k]], (k == 4) ? 1 : 0); end
        end
        enable = 1'b0;
        step();
        checks++;
        if (obs !== 8'h47) begin errors++; $display("FAIL div0_stop_adv obs=%h exp=47", obs); end
        step();
        checks++;
        if (obs !== 8'h04 || lo_cycles !== 8'd1) begin errors++; $display("FAIL div0_idle obs=%h lo=%0d exp=04 lo=1", obs, lo_cycles); end
    endtask

    task automatic test_invert_div3;
        logic [1:0] ph [5] = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
        logic [7:0] exp;
        enable = 1'b1; phase_init = 2'd2; invert = 1'b1; div = 4'd3;
        step();
        checks++;
        if (obs !== 8'h05) begin errors++; $display("FAIL inv_arm obs=%h exp=05", obs); end
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 4; j++) begin
                step();
                exp = (j == 0) ? STRB[ph[k]] : STRB[ph[k]] - 8'd2;
                checks++;
                if (obs !== exp || lo_cycles !== ((k >= 3) ? 8'd1 : 8'd0))
                    begin errors++; $display("FAIL inv_seq%0d_%0d obs=%h lo=%0d exp=%h lo=%0d", k, j, obs, lo_cycles, exp, (k >= 3) ? 1 : 0); end
            end
    endtask

    task automatic test_stop;
        step();
        checks++;
        if (obs !== 8'h47) begin errors++; $display("FAIL stop_strobe obs=%h exp=47", obs); end
        step();
        enable = 1'b0;
        for (int j = 0; j < 2; j++) begin
            step();
            checks++;
            if (obs !== 8'h45) begin errors++; $display("FAIL stop_hold%0d obs=%h exp=45", j, obs); end
        end
        for (int j = 0; j < 2; j++) begin
            step();
            checks++;
            if (obs !== 8'h04 || lo_cycles !== 8'd1) begin errors++; $display("FAIL stop_idle%0d obs=%h lo=%0d exp=04 lo=1", j, obs, lo_cycles); end
        end
    endtask

    task automatic test_stop_resume;
        logic [7:0] exp;
        enable = 1'b1; phase_init = 2'd0; invert = 1'b0; div = 4'd3;
        step();
        checks++;
        if (obs !== 8'h05) begin errors++; $display("FAIL res_arm obs=%h exp=05", obs); end
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 4; j++) begin
                step();
                exp = (j == 0) ? STRB[p] : STRB[p] - 8'd2;
                checks++;
                if (obs !== exp || lo_cycles !== 8'd0) begin errors++; $display("FAIL res_seq%0d_%0d obs=%h lo=%0d exp=%h lo=0", p, j, obs, lo_cycles, exp); end
            end
        step();
        checks++;
        if (obs !== 8'h13 || lo_cycles !== 8'd1) begin errors++; $display("FAIL res_wrap obs=%h lo=%0d exp=13 lo=1", obs, lo_cycles); end
        step();
        enable = 1'b0;
        step();
        checks++;
        if (obs !== 8'h11) begin errors++; $display("FAIL res_in_stop obs=%h exp=11", obs); end
        enable = 1'b1;
        step();
        step();
        checks++;
        if (obs !== 8'h47 || lo_cycles !== 8'd1) begin errors++; $display("FAIL res_cadence obs=%h lo=%0d exp=47 lo=1", obs, lo_cycles); end
        invert = 1'b1; div = 4'd0;
        for (int j = 0; j < 3; j++) begin
            step();
            checks++;
            if (obs !== 8'h45) begin errors++; $display("FAIL latch_hold%0d obs=%h exp=45", j, obs); end
        end
        step();
        checks++;
        if (obs !== 8'h3B) begin errors++; $display("FAIL latch_adv obs=%h exp=3b", obs); end
    endtask

    task automatic test_reset_midrun;
        reset = 1'b1;
        #1;
        checks++;
        if ({obs, lo_cycles} !== 16'h0) begin errors++; $display("FAIL async_reset1 obs=%h lo=%0d exp=00 lo=0", obs, lo_cycles); end
        step();
        phase_init = 2'd3; invert = 1'b0; div = 4'd7; reset = 1'b0;
        step();
        checks++;
        if (obs !== 8'h01) begin errors++; $display("FAIL rst_arm obs=%h exp=01", obs); end
        step();
        checks++;
        if (obs !== 8'hCF || lo_cycles !== 8'd0) begin errors++; $display("FAIL rst_first obs=%h lo=%0d exp=cf lo=0", obs, lo_cycles); end
        repeat (7) step();
        checks++;
        if (obs !== 8'hCD) begin errors++; $display("FAIL rst_hold obs=%h exp=cd", obs); end
        step();
        checks++;
        if (obs !== 8'h13 || lo_cycles !== 8'd1) begin errors++; $display("FAIL rst_div7_adv obs=%h lo=%0d exp=13 lo=1", obs, lo_cycles); end
        repeat (3) step();
        reset = 1'b1;
        #1;
        checks++;
        if ({obs, lo_cycles} !== 16'h0) begin errors++; $display("FAIL async_reset2 obs=%h lo=%0d exp=00 lo=0", obs, lo_cycles); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_wrap;
        phase_init = 2'd0; invert = 1'b0; div = 4'd0; enable = 1'b1;
        step();
        step();
        checks++;
        if (obs !== 8'h13 || lo_cycles !== 8'd0) begin errors++; $display("FAIL wrap_first obs=%h lo=%0d exp=13 lo=0", obs, lo_cycles); end
        repeat (1022) step();
        step();
        checks++;
        if (obs !== 8'hCF || lo_cycles !== 8'd255) begin errors++; $display("FAIL wrap_1024 obs=%h lo=%0d exp=cf lo=255", obs, lo_cycles); end
        div = 4'd5; invert = 1'b1;
        step();
        checks++;
        if (obs !== 8'h13 || lo_cycles !== 8'd0) begin errors++; $display("FAIL wrap_zero obs=%h lo=%0d exp=13 lo=0", obs, lo_cycles); end
        step();
        checks++;
        if (obs !== 8'h47) begin errors++; $display("FAIL wrap_latched obs=%h exp=47", obs); end
        enable = 1'b0;
        step();
        step();
        checks++;
        if (obs !== 8'h08 || lo_cycles !== 8'd0) begin errors++; $display("FAIL wrap_idle obs=%h lo=%0d exp=08 lo=0", obs, lo_cycles); end
    endtask

    initial begin
        test_reset();
        test_div0();
        test_invert_div3();
        test_stop();
        test_stop_resume();
        test_reset_midrun();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lo_sequencer.md
# lo_sequencer

Controller for the IQ down-conversion demodulator. It generates the quarter-rate local-oscillator code sequence (`sine_in`/`cosine_in` values 0, +1, −1) that drives the demodulator. It also paces the IF sample stream with a programmable strobe, handles start/stop sequencing, and counts completed LO periods. It sits between the receive control registers and the demodulator; the demodulator's baseband outputs are valid in every cycle where `sample_strobe` is high.

## Interface

Parameters:
- `DIV_W`, default 4: width of the sample-period divider.
- `CNT_W`, default 8: width of the completed-LO-period counter.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request; level-sensitive.
- `phase_init` in 2: starting LO phase index, latched at start.
- `invert` in 1: 0 = phase increments, 1 = phase decrements (spectral inversion); latched at start.
- `div` in DIV_W: sample period minus one, in clocks; latched at start.
- `sine_out` in→out 2 (output): LO sine code to the demodulator; 2'b00 = 0, 2'b01 = +1, 2'b11 = −1.
- `cosine_out` out 2: LO cosine code to the demodulator, same encoding.
- `phase` out 2: current phase index.
- `sample_strobe` out 1: one-cycle pulse marking a new IF sample and a new LO code.
- `busy` out 1: high in ARM, RUN and STOP.
- `lo_cycles` out CNT_W: number of completed 4-phase LO periods since start.

## Operation

- Phase to code map (sine, cosine):
  - 0: (00, 01)
  - 1: (01, 00)
  - 2: (00, 11)
  - 3: (11, 00)
- Codes 2'b10 are never driven.
- All outputs are registered.
- FSM states:
  - IDLE:
    - Codes (00, 00), so the demodulator outputs zero.
    - `sample_strobe` = 0, `busy` = 0.
    - `enable` = 1 → ARM.
  - ARM (exactly one cycle):
    - Latch `phase_init`, `invert`, `div`.
    - Clear `div_cnt` and `lo_cycles`.
    - → RUN unconditionally; `enable` is ignored during this cycle.
  - RUN:
    - `div_cnt` counts 0..div_latched.
    - When `div_cnt` == div_latched: `div_cnt` returns to 0 and phase advances (+1 mod 4, or −1 mod 4 if inverted) on the next cycle.
    - `enable` = 0 → STOP.
  - STOP:
    - Finish the current sample period with counting and phase behaviour identical to RUN.
    - At `div_cnt` == div_latched → IDLE; no further strobe, no phase advance.
    - `enable` = 1 in STOP → RUN, continuing without re-arm.
- `lo_cycles` increments on the phase wrap 3→0 (normal) or 0→3 (inverted).
- `lo_cycles` wraps modulo 2^CNT_W and holds its value in IDLE.
- Changes to `phase_init`, `invert` or `div` outside ARM have no effect.

## Timing

- Reset values: state = IDLE, `sine_out` = 00, `cosine_out` = 00, `phase` = 0, `sample_strobe` = 0, `busy` = 0, `lo_cycles` = 0, `div_cnt` = 0.
- Start latency: `enable` sampled high at edge N → ARM at N. At edge N+1, the outputs enter RUN: `phase` = phase_init, the codes follow the map, `sample_strobe` = 1, and `busy` is already high from edge N.
- In RUN, `sample_strobe` is high for exactly one cycle every div_latched+1 clocks, coincident with each code update, including the first RUN cycle.
- `div` = 0: strobe is high every cycle and the phase advances every cycle.
- Stop: after `enable` falls, the current code is held until its period ends. At the following edge the codes become (00, 00), `busy` = 0, and `sample_strobe` = 0.
- Reset asserted mid-run: all outputs are forced to their reset values asynchronously; there is no drain.
- `enable` toggled within one period during STOP: there is no glitch on the strobe cadence.

## Test plan

- Reset, then `enable` = 1, `phase_init` = 0, `invert` = 0, `div` = 0 → from the second cycle: codes (00,01), (01,00), (00,11), (11,00) repeating; strobe high continuously; `lo_cycles` = 1 after 4 strobes.
- `div` = 3, `phase_init` = 2, `invert` = 1 → strobe every 4 clocks; phases 2, 1, 0, 3, 2; `lo_cycles` increments on the 0→3 transition.
- RUN with `div` = 3; drop `enable` one cycle after a strobe → code held 3 more cycles, then (00, 00), `busy` = 0, no extra strobe.
- `enable` falls and then re-rises within the STOP period → no IDLE visit, strobe cadence unchanged, `lo_cycles` not cleared.
- `reset` pulsed mid-period with `div` = 7 → all outputs at reset values immediately; after release plus `enable`, one ARM cycle, then phase = phase_init.
- `lo_cycles` wrap: `div` = 0 run for 1024 strobes → `lo_cycles` returns to 0; change `div`/`invert` mid-run → no effect until the next ARM.
